// File: rtl/riscv_pkg.sv
// Shared register-file definitions used by the writeback path.
package riscv_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int WORD_SIZE  = 32;

    // One buffered result: destination register plus its value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [WORD_SIZE-1:0]  data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Load-result buffer: power-of-two depth, head entry visible combinationally.
module wb_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  wb_entry_t                push_entry,
    output wb_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    // Pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/writeback_unit.sv
// Writeback arbiter: ALU results win the register-file write port, buffered
// loads drain in the gaps, and a busy scoreboard tracks in-flight destinations.
module writeback_unit
    import riscv_pkg::*;
#(
    parameter int WORD_SIZE   = 32,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_rd,
    input  logic                 alu_valid,
    input  logic [4:0]           alu_rd,
    input  logic [WORD_SIZE-1:0] alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [4:0]           mem_rd,
    input  logic [WORD_SIZE-1:0] mem_data,
    output logic                 rf_write_enable,
    output logic [4:0]           rf_write_addr,
    output logic [WORD_SIZE-1:0] rf_write_data,
    output logic [31:0]          busy_mask,
    output logic                 issue_conflict
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    wb_entry_t            push_entry;
    wb_entry_t            head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic                 push;
    logic                 pop;
    logic                 alu_win;

    logic                 sel_we;
    logic [4:0]           sel_addr;
    logic [WORD_SIZE-1:0] sel_data;

    logic [31:0]          set_mask;
    logic [31:0]          clr_mask;
    logic                 conflict_next;

    // Ready looks only at the registered count, so a full buffer stays
    // unready even in a cycle where it drains.
    assign mem_ready = reset_n && (fifo_count < CNT_W'(QUEUE_DEPTH));
    // Full is implied by ready; gating on it too means a bad ready path can
    // never overwrite an unread entry.
    assign push      = mem_valid && mem_ready && !fifo_full;

    assign push_entry.rd   = mem_rd;
    assign push_entry.data = mem_data;

    // An rd=0 ALU result is dropped and leaves the port free for the FIFO.
    assign alu_win = alu_valid && (alu_rd != '0);
    assign pop     = !alu_win && !fifo_empty;

    wb_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .pop        (pop),
        .push_entry (push_entry),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // Port selection; x0 loads still pop but never raise the write enable.
    always_comb begin
        sel_we   = 1'b0;
        sel_addr = rf_write_addr;
        sel_data = rf_write_data;
        if (alu_win) begin
            sel_we   = 1'b1;
            sel_addr = alu_rd;
            sel_data = alu_data;
        end else if (pop) begin
            sel_we   = (head.rd != '0);
            sel_addr = head.rd;
            sel_data = head.data;
        end
    end

    // Registered write port driving the register file directly.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rf_write_enable <= 1'b0;
            rf_write_addr   <= '0;
            rf_write_data   <= '0;
        end else begin
            rf_write_enable <= sel_we;
            rf_write_addr   <= sel_addr;
            rf_write_data   <= sel_data;
        end
    end

    // A bit clears on the edge the file captures the write; a same-cycle
    // issue of that register counts as a fresh producer, not a WAW.
    always_comb begin
        set_mask      = '0;
        clr_mask      = '0;
        if (issue_valid && issue_rd != '0) set_mask = 32'd1 << issue_rd;
        if (rf_write_enable)               clr_mask = 32'd1 << rf_write_addr;
        conflict_next = issue_valid && (issue_rd != '0) &&
                        busy_mask[issue_rd] && !clr_mask[issue_rd];
    end

    // Scoreboard register: set wins over clear on the same bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_mask      <= '0;
            issue_conflict <= 1'b0;
        end else begin
            busy_mask      <= (busy_mask & ~clr_mask) | set_mask;
            issue_conflict <= conflict_next;
        end
    end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Write-side initiator for the general-purpose register file: collects results from the single-cycle ALU path and the multi-cycle load path, arbitrates them onto the register file's single write port, and tracks pending destination registers so decode can stall. It sits between execute/memory and the register file. It drives the file's `write_enable`, `write_addr` and `write_data` inputs directly.

## Interface
- `WORD_SIZE`, 32, data width of every result and of the register file.
- `QUEUE_DEPTH`, 4, load-result buffer entries; power of two, ≥2.
- `clock`  in  1  rising-edge clock shared with the register file.
- `reset_n`  in  1  asynchronous, active-low reset.
- `issue_valid`  in  1  decode issues an instruction that will write `issue_rd`.
- `issue_rd`  in  5  destination of the issued instruction.
- `alu_valid`  in  1  ALU result present this cycle; always accepted.
- `alu_rd`  in  5  ALU destination.
- `alu_data`  in  WORD_SIZE  ALU result.
- `mem_valid`  in  1  load result offered.
- `mem_ready`  out  1  buffer can accept a load result.
- `mem_rd`  in  5  load destination.
- `mem_data`  in  WORD_SIZE  load result.
- `rf_write_enable`  out  1  to register file `write_enable`.
- `rf_write_addr`  out  5  to register file `write_addr`.
- `rf_write_data`  out  WORD_SIZE  to register file `write_data`.
- `busy_mask`  out  32  bit i set = register i has a result in flight.
- `issue_conflict`  out  1  one-cycle pulse: issue to an already-busy rd (WAW, illegal).

## Operation
- Load transfer occurs when `mem_valid && mem_ready`. The entry {rd, data} is pushed into the FIFO.
- `mem_ready` = (count < QUEUE_DEPTH) and not in reset. It depends only on the registered count, with no same-cycle bypass. When the buffer is full, `mem_ready` is 0 even if the buffer drains that cycle.
- Port arbitration is evaluated each cycle:
  - An ALU result with `alu_valid && alu_rd != 0` wins the port.
  - Otherwise, if the FIFO is non-empty, the head entry is popped and written.
  - An ALU result with rd = 0 is discarded and does not occupy the port, so the FIFO may drain that cycle.
  - A load with rd = 0 is enqueued, popped normally and dropped at the port, with `rf_write_enable` = 0.
- Writes to x0 never assert `rf_write_enable`.
- Scoreboard:
  - `issue_valid && issue_rd != 0` sets `busy_mask[issue_rd]`.
  - A committed write to rd clears `busy_mask[rd]`.
  - When a set and a clear hit the same rd in the same cycle, the set wins.
  - An issue to a busy rd pulses `issue_conflict` and leaves the bit set.
- Simultaneous enqueue and dequeue leaves count unchanged. Pointers wrap modulo QUEUE_DEPTH.

## Timing
- All outputs except `mem_ready` are registered.
- Latency:
  - A result selected at rising edge N appears on `rf_*` after edge N.
  - The register file captures it at edge N+1.
  - `busy_mask` clears after edge N+1, in the same cycle the file contents update.
  - The register file reads on the falling edge, so decode sees the new value in that same cycle without forwarding.
- Load path minimum latency is enqueue edge N, pop edge N+1, file write edge N+2.
- An ALU result every cycle starves the FIFO indefinitely. This is accepted behaviour: the upstream pipeline guarantees bubbles.
- Reset values: `rf_write_enable`=0, `rf_write_addr`=0, `rf_write_data`=0, `busy_mask`=0, `issue_conflict`=0, `mem_ready`=0 while `reset_n` is low, FIFO count and pointers 0.
- Reset mid-operation discards buffered loads and any pending write. The register file is not written afterwards.

## Structure
- The shared package `riscv_pkg` holds:
  - `REG_ADDR_W`=5 and `NUM_REGS`=32.
  - `wb_entry_t` struct {rd[4:0], data[WORD_SIZE-1:0]}, with WORD_SIZE taken as 32 in the package.
- One sub-module, `wb_fifo`:
  - Parameterised by depth.
  - push/pop/full/empty/count interface.
  - Head data visible combinationally.
- Arbitration, registered write outputs and scoreboard live in `writeback_unit`.

## Test plan
- Reset, then `alu_valid`, rd=5, data=0xDEADBEEF → `rf_write_enable`=1, addr 5, data 0xDEADBEEF one cycle later; register 5 reads 0xDEADBEEF after the next edge.
- Issue rd=7, then load rd=7 data=0x1234 while ALU idle → `busy_mask[7]`=1 until the file write at enqueue+2 edges, then 0.
- Hold `alu_valid` (rd=1..4) for 6 cycles while pushing 5 loads → `mem_ready` drops after 4 accepted. No load is written until ALU goes idle, then loads drain in FIFO order, one per cycle.
- ALU rd=0 plus a pending load in the same cycle → the load is written that cycle; x0 is never written and reads 0.
- Issue rd=9 twice without a commit → `issue_conflict` pulses once and `busy_mask[9]` stays 1. An issue of rd=9 in the same cycle as rd=9's commit leaves bit 9 set.
- Assert `reset_n`=0 with 3 buffered loads → all outputs return to 0 asynchronously, and no write occurs after release.
